div_impl: RTL
=============

# div_impl

Sequential unsigned restoring divider: the inverse operation of the team's combinational multiplier, recovering quotient and remainder from a dividend and a divisor. It computes one quotient bit per clock and uses a valid/ready handshake on both its input and output sides. It sits in the arithmetic test corpus next to the adder and multiplier implementations, and serves as the multi-cycle, stateful member of that set for equivalence and simulation flows.

## Interface
Parameters:
- N_WIDTH, default 8: dividend and quotient width.
- D_WIDTH, default 4: divisor and remainder width. Must satisfy D_WIDTH ≤ N_WIDTH.

Ports:
- clk, input, 1: single clock, all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: the operands are valid.
- in_ready, output, 1: the block can accept operands. High only in IDLE.
- dividend, input, N_WIDTH: unsigned dividend.
- divisor, input, D_WIDTH: unsigned divisor.
- out_valid, output, 1: the result is valid. High only in DONE.
- out_ready, input, 1: the consumer accepts the result.
- quotient, output, N_WIDTH: unsigned quotient.
- remainder, output, D_WIDTH: unsigned remainder.
- div_by_zero, output, 1: the current result came from divisor == 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- IDLE transitions (on in_valid && in_ready):
  - Operands are latched.
  - If divisor == 0, go to DONE with quotient = all ones, remainder = 0, div_by_zero = 1.
  - Otherwise, clear the iteration counter, clear the partial remainder (D_WIDTH+1 bits internally), clear div_by_zero, and go to BUSY.
- BUSY iteration, one per cycle, MSB of the dividend first:
  - pr = {pr[D_WIDTH-1:0], next dividend bit}.
  - If pr ≥ divisor: pr = pr − divisor and the quotient bit = 1; otherwise the quotient bit = 0.
  - The quotient shifts in LSB-last.
- After N_WIDTH iterations, go to DONE with quotient/remainder final. The remainder is always < divisor, so it fits in D_WIDTH bits.
- DONE: outputs are held stable until out_valid && out_ready, then go to IDLE.
- Operand inputs and in_valid are ignored outside IDLE; there is no overlap of operations.
- quotient, remainder and div_by_zero are registered. Their values outside DONE are don't-care for consumers, but they must keep their last value.
- Invariant on every non-zero result: dividend == quotient*divisor + remainder.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0.
- Reset has priority over all handshakes. Reset asserted in BUSY or DONE aborts the operation and discards the result; the cycle after reset deasserts shows in_ready = 1.
- Latency, from the accept edge to the first cycle with out_valid = 1:
  - N_WIDTH cycles for non-zero divisors (8 for defaults).
  - 1 cycle for divide-by-zero.
- in_ready is low from the cycle after accept until the cycle after the output handshake.
- Minimum accept-to-accept interval:
  - N_WIDTH + 2 cycles when out_ready is held high.
  - 2 cycles for divide-by-zero.
- out_valid, once high, stays high with stable outputs until out_ready is sampled high. out_valid drops the cycle after that handshake.
- in_valid and out_ready are sampled only on rising edges. Combinational changes do not affect the outputs within a cycle, because there are no combinational input-to-output paths.

## Test plan
- Basic division: accept 200 / 7 (defaults), out_ready = 1. Expected: out_valid high exactly 8 cycles after accept; quotient = 28, remainder = 4, div_by_zero = 0.
- Extremes: 255 / 15 → 17 rem 0. 255 / 1 → 255 rem 0. 0 / 5 → 0 rem 0. 6 / 9 → 0 rem 6. Each must hold in 8 cycles.
- Divide by zero: 9 / 0. Expected: out_valid 1 cycle after accept; quotient = 8'hFF, remainder = 0, div_by_zero = 1. A following 10 / 3 must return 3 rem 1 with div_by_zero = 0.
- Backpressure: 100 / 3 with out_ready held low 5 cycles past out_valid. Expected: out_valid stays 1 and quotient = 33, remainder = 1 stay constant; in_ready stays 0 and in_valid pulses are ignored; handshake on out_ready = 1, then in_ready = 1 on the next cycle.
- Reset mid-operation: assert reset 3 cycles into BUSY for 1 cycle. Expected: next cycle in_ready = 1, out_valid = 0, all outputs 0. A new 50 / 6 returns 8 rem 2 in 8 cycles.
- Randomized back-to-back: 1000 random operand pairs with random in_valid/out_ready gaps. Expected: every result matches dividend/divisor and dividend%divisor, or the divide-by-zero encoding; no result is lost or duplicated.

Source files
------------

// File: rtl/div_impl.sv
// div_impl: sequential unsigned restoring divider. One quotient bit is
// produced per clock, MSB first, with valid/ready handshakes on the operand
// side and on the result side. Requires 2 <= D_WIDTH <= N_WIDTH.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready_o high
// BUSY   | one restoring step per cycle, dividend MSB first
// DONE   | result presented and held until the consumer takes it
module div_impl #(
  parameter int N_WIDTH = 8,
  parameter int D_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [N_WIDTH-1:0] dividend_i,
  input  logic [D_WIDTH-1:0] divisor_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [N_WIDTH-1:0] quotient_o,
  output logic [D_WIDTH-1:0] remainder_o,
  output logic               div_by_zero_o
);

  localparam int CNT_W = $clog2(N_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after N_WIDTH steps this register holds the full quotient.
  logic [N_WIDTH-1:0] dvd_q, dvd_d;
  logic [D_WIDTH-1:0] dsr_q, dsr_d;
  // The stored partial remainder is always below the divisor, so it fits in
  // D_WIDTH bits; the shifted trial value below carries the extra bit.
  logic [D_WIDTH-1:0] pr_q, pr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_WIDTH-1:0] quo_q, quo_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic               dz_q, dz_d;

  logic [D_WIDTH:0]   pr_shift;
  logic [D_WIDTH:0]   pr_diff;
  logic               q_bit;
  logic [D_WIDTH-1:0] pr_next;
  logic [N_WIDTH-1:0] dvd_next;

  // One restoring step. The trial difference lies within +/- divisor, so its
  // top bit is exactly the borrow: clear means the subtraction is kept.
  always_comb begin
    pr_shift = {pr_q, dvd_q[N_WIDTH-1]};
    pr_diff  = pr_shift - {1'b0, dsr_q};
    q_bit    = ~pr_diff[D_WIDTH];
    pr_next  = q_bit ? pr_diff[D_WIDTH-1:0] : pr_shift[D_WIDTH-1:0];
    dvd_next = {dvd_q[N_WIDTH-2:0], q_bit};
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          dvd_d = dividend_i;
          dsr_d = divisor_i;
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            pr_d    = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        dvd_d = dvd_next;
        pr_d  = pr_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          quo_d   = dvd_next;
          rem_d   = pr_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over any handshake in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Working and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dvd_q <= '0;
      dsr_q <= '0;
      pr_q  <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      pr_q  <= pr_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end

  assign in_ready_o    = (state_q == S_IDLE);
  assign out_valid_o   = (state_q == S_DONE);
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dz_q;

endmodule
